// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if
// Bundles every signal of the burst controller apart from clk/reset:
//   request channel    : req_valid, req_ready, req_write, req_addr, req_len
//   write data channel : wr_data_valid, wr_data_ready, wr_data
//   read data channel  : rd_valid, rd_data, rd_last
//   status             : done, busy
//   memory pins        : mem_wr_en, mem_rd_en, mem_address, mem_wdata, mem_rdata
// Modport slave is used by the controller; master is the view of the
// environment around it (requester plus memory).
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              busy;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_data_valid, wr_data, mem_rdata,
    output req_ready, wr_data_ready, rd_valid, rd_data, rd_last,
    output done, busy, mem_wr_en, mem_rd_en, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wr_data_valid, wr_data, mem_rdata,
    input  req_ready, wr_data_ready, rd_valid, rd_data, rd_last,
    input  done, busy, mem_wr_en, mem_rd_en, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Burst access controller sitting in front of a single-port memory whose
// read data is registered (1-cycle latency). Accepts one burst at a time,
// streams write beats into the memory or read beats out of it, and walks
// sequential addresses that wrap at the top of the address space.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, aborts any burst in flight
//   bus   - mem_burst_ctrl_if.slave carrying request, write data, read
//           data, status and memory pins
module mem_burst_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_burst_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [LEN_W-1:0]  remaining, remaining_next;
  logic              write_done_q, write_done_next;
  logic              rd_valid_q;

  logic              req_ready_c;
  logic              wr_ready_c;
  logic              mem_wr_en_c;
  logic              mem_rd_en_c;

  // State, address and beat counters. rd_valid_q is the issue strobe
  // delayed by one cycle to line up with the memory's registered rdata;
  // write_done_q turns the final write beat into a done pulse in the
  // following (IDLE) cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      write_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state        <= state_next;
      addr         <= addr_next;
      remaining    <= remaining_next;
      write_done_q <= write_done_next;
      rd_valid_q   <= (state == READ);
    end
  end

  // Next-state and handshake/memory-strobe decode. Address arithmetic is
  // naturally modulo 2^ADDR_W, which gives the wrap for free.
  always_comb begin
    state_next      = state;
    addr_next       = addr;
    remaining_next  = remaining;
    write_done_next = 1'b0;
    req_ready_c     = 1'b0;
    wr_ready_c      = 1'b0;
    mem_wr_en_c     = 1'b0;
    mem_rd_en_c     = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = ~reset;
        if (bus.req_valid && req_ready_c) begin
          addr_next      = bus.req_addr;
          remaining_next = bus.req_len;
          state_next     = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready_c  = 1'b1;
        mem_wr_en_c = bus.wr_data_valid;
        if (bus.wr_data_valid) begin
          addr_next      = addr + 1'b1;
          remaining_next = remaining - 1'b1;
          if (remaining == '0) begin
            state_next      = IDLE;
            write_done_next = 1'b1;
          end
        end
      end
      READ: begin
        mem_rd_en_c    = 1'b1;
        addr_next      = addr + 1'b1;
        remaining_next = remaining - 1'b1;
        if (remaining == '0) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.wr_data_ready = wr_ready_c;
  assign bus.mem_wr_en     = mem_wr_en_c;
  assign bus.mem_rd_en     = mem_rd_en_c;
  assign bus.mem_address   = addr;
  assign bus.mem_wdata     = bus.wr_data;
  assign bus.rd_data       = bus.mem_rdata;
  assign bus.rd_valid      = rd_valid_q;
  // FLUSH is exactly the cycle carrying the last read beat.
  assign bus.rd_last       = (state == FLUSH);
  assign bus.done          = write_done_q | (state == FLUSH);
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl
// Bench for mem_burst_ctrl. Contains a 1024x8 memory with registered read
// data, a transaction-level model (expected write list, expected read list,
// shadow memory) and a negedge compare process, plus directed bursts with
// literal expectations.
module tb_mem_burst_ctrl;

  logic clk;
  logic reset;

  mem_burst_ctrl_if #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) bus ();

  mem_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the controller: write wins, read data registered
  logic [7:0] mem_array [0:1023];
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem_array[bus.mem_address] <= bus.mem_wdata;
    end else if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem_array[bus.mem_address];
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0] shadow [0:1023];
  logic [9:0] exp_wr_addr [$];
  logic [7:0] exp_wr_data [$];
  logic       exp_wr_last [$];
  logic [7:0] exp_rd_data [$];
  logic       exp_rd_last [$];
  logic       done_due = 1'b0;

  // Observation logs used by the directed checks
  logic [9:0] obs_wr_addr [$];
  logic [7:0] obs_rd_data [$];
  logic       obs_rd_last [$];
  int         obs_rd_cyc  [$];

  logic [7:0] wbuf [0:15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: actual=no event required=event within bound", name);
  endtask

  // A write burst of len+1 beats lands wbuf[i] at (a+i) mod 1024
  task automatic model_write(input logic [9:0] a, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_wr_addr.push_back(a + 10'(i));
      exp_wr_data.push_back(wbuf[i]);
      exp_wr_last.push_back(i == len);
    end
  endtask

  // A read burst returns shadow contents in address order, last on beat len
  task automatic model_read(input logic [9:0] a, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_rd_data.push_back(shadow[a + 10'(i)]);
      exp_rd_last.push_back(i == len);
    end
  endtask

  // Compare process: every out-of-reset cycle the memory strobes, read
  // channel and done are checked against the model.
  logic [9:0] m_a;
  logic [7:0] m_d;
  logic       m_l;
  logic       exp_done;
  logic       exp_last;
  always @(negedge clk) begin
    if (reset) begin
      exp_wr_addr.delete();
      exp_wr_data.delete();
      exp_wr_last.delete();
      exp_rd_data.delete();
      exp_rd_last.delete();
      done_due = 1'b0;
    end else begin
      exp_done = done_due;
      done_due = 1'b0;
      exp_last = 1'b0;
      checkOutput("excl_enables", 32'(bus.mem_wr_en & bus.mem_rd_en), 32'd0);
      checkOutput("wr_en_handshake", 32'(bus.mem_wr_en), 32'(bus.wr_data_valid & bus.wr_data_ready));
      if (bus.mem_wr_en) begin
        if (exp_wr_addr.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          m_a = exp_wr_addr.pop_front();
          m_d = exp_wr_data.pop_front();
          m_l = exp_wr_last.pop_front();
          checkOutput("wr_addr", 32'(bus.mem_address), 32'(m_a));
          checkOutput("wr_data", 32'(bus.mem_wdata), 32'(m_d));
          shadow[m_a] = m_d;
          done_due = m_l;
          obs_wr_addr.push_back(bus.mem_address);
        end
      end
      if (bus.rd_valid) begin
        if (exp_rd_data.size() == 0) begin
          fail_now("unexpected_rd_valid");
        end else begin
          m_d = exp_rd_data.pop_front();
          m_l = exp_rd_last.pop_front();
          exp_last = m_l;
          checkOutput("rd_data", 32'(bus.rd_data), 32'(m_d));
          obs_rd_data.push_back(bus.rd_data);
          obs_rd_last.push_back(bus.rd_last);
          obs_rd_cyc.push_back(cyc);
        end
      end
      checkOutput("rd_last", 32'(bus.rd_last), 32'(exp_last));
      checkOutput("done", 32'(bus.done), 32'(exp_done | exp_last));
    end
  end

  // Write burst driver. Starts presenting the request immediately, so a call
  // made in a done cycle exercises back-to-back acceptance. Returns in the
  // cycle after the final beat (the done cycle).
  task automatic applyStimulus(input logic [9:0] a, input int len, input logic [15:0] pat,
                               input int pat_len, output int wait_cycles);
    int beat;
    int k;
    int guard;
    logic acc;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = 8'(len);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    wait_cycles = guard;
    if (guard >= 50) fail_now("wr_req_timeout");
    model_write(a, len);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    beat  = 0;
    k     = 0;
    guard = 0;
    while (beat <= len && guard < 200) begin
      bus.wr_data_valid = (k < pat_len) ? pat[k[3:0]] : 1'b1;
      bus.wr_data       = wbuf[beat[3:0]];
      #1;
      acc = bus.wr_data_valid & bus.wr_data_ready;
      @(posedge clk); #1;
      if (acc) beat++;
      k++;
      guard++;
    end
    bus.wr_data_valid = 1'b0;
    if (guard >= 200) fail_now("wr_beat_timeout");
  endtask

  // Read burst driver; returns in the first IDLE cycle after the burst.
  task automatic applyReadStimulus(input logic [9:0] a, input int len);
    int guard;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = 8'(len);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) fail_now("rd_req_timeout");
    model_read(a, len);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.done && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) fail_now("rd_done_timeout");
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    fail_now("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  int n0;
  int wc;
  logic [7:0] lit_a [0:3];
  logic [7:0] lit_w [0:3];
  logic [7:0] lit_d [0:2];
  logic [9:0] lit_wa [0:3];

  initial begin
    lit_a  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    lit_w  = '{8'h11, 8'h22, 8'h33, 8'h44};
    lit_d  = '{8'hD0, 8'hD1, 8'hD2};
    lit_wa = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_len       = '0;
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
    reset = 1'b1;
    #3;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    checkOutput("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("rst_wr_ready", 32'(bus.wr_data_ready), 32'd0);
    checkOutput("rst_mem_address", 32'(bus.mem_address), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Basic write then read-back
    $display("[TB] write/read 0x010 len 3");
    for (int i = 0; i < 4; i++) wbuf[i] = lit_a[i];
    n0 = obs_wr_addr.size();
    applyStimulus(10'h010, 3, 16'hFFFF, 0, wc);
    checkOutput("t1_done", 32'(bus.done), 32'd1);
    checkOutput("t1_write_count", 32'(obs_wr_addr.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("t1_wr_addr", 32'(obs_wr_addr[n0 + i]), 32'h010 + 32'(i));
    @(posedge clk); #1;
    checkOutput("t1_done_one_cycle", 32'(bus.done), 32'd0);
    n0 = obs_rd_data.size();
    applyReadStimulus(10'h010, 3);
    checkOutput("t1_rd_count", 32'(obs_rd_data.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_rd_data", 32'(obs_rd_data[n0 + i]), 32'(lit_a[i]));
      checkOutput("t1_rd_last", 32'(obs_rd_last[n0 + i]), 32'(i == 3));
    end
    checkOutput("t1_rd_consecutive", 32'(obs_rd_cyc[n0 + 3] - obs_rd_cyc[n0]), 32'd3);

    // Address wrap
    $display("[TB] wrap at 0x3FE");
    for (int i = 0; i < 4; i++) wbuf[i] = lit_w[i];
    n0 = obs_wr_addr.size();
    applyStimulus(10'h3FE, 3, 16'hFFFF, 0, wc);
    for (int i = 0; i < 4; i++) checkOutput("wrap_wr_addr", 32'(obs_wr_addr[n0 + i]), 32'(lit_wa[i]));
    @(posedge clk); #1;
    n0 = obs_rd_data.size();
    applyReadStimulus(10'h3FE, 3);
    for (int i = 0; i < 4; i++) checkOutput("wrap_rd_data", 32'(obs_rd_data[n0 + i]), 32'(lit_w[i]));

    // Write backpressure: valid pattern 1,0,0,1,1
    $display("[TB] write backpressure");
    wbuf[0] = 8'h71; wbuf[1] = 8'h72; wbuf[2] = 8'h73;
    n0 = obs_wr_addr.size();
    applyStimulus(10'h100, 2, 16'h0019, 5, wc);
    checkOutput("bp_done", 32'(bus.done), 32'd1);
    checkOutput("bp_write_count", 32'(obs_wr_addr.size() - n0), 32'd3);
    for (int i = 0; i < 3; i++) checkOutput("bp_wr_addr", 32'(obs_wr_addr[n0 + i]), 32'h100 + 32'(i));
    @(posedge clk); #1;

    // Single-beat read of 0x055 holding 5A
    $display("[TB] single-beat read");
    wbuf[0] = 8'h5A;
    applyStimulus(10'h055, 0, 16'hFFFF, 0, wc);
    checkOutput("sb_wr_done", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h055;
    bus.req_len   = 8'd0;
    model_read(10'h055, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("sb_rd_en", 32'(bus.mem_rd_en), 32'd1);
    checkOutput("sb_rd_addr", 32'(bus.mem_address), 32'h055);
    checkOutput("sb_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("sb_rd_en_off", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("sb_rd_valid", 32'(bus.rd_valid), 32'd1);
    checkOutput("sb_rd_last", 32'(bus.rd_last), 32'd1);
    checkOutput("sb_done", 32'(bus.done), 32'd1);
    checkOutput("sb_rd_data", 32'(bus.rd_data), 32'h5A);
    checkOutput("sb_req_ready_flush", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("sb_req_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("sb_rd_valid_after", 32'(bus.rd_valid), 32'd0);

    // Reset in the middle of an 8-beat read
    $display("[TB] reset mid-read");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h010;
    bus.req_len   = 8'd7;
    model_read(10'h010, 7);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("mr_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mr_busy", 32'(bus.busy), 32'd0);
    checkOutput("mr_rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("mr_rd_last", 32'(bus.rd_last), 32'd0);
    checkOutput("mr_done", 32'(bus.done), 32'd0);
    checkOutput("mr_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    checkOutput("mr_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
    checkOutput("mr_mem_address", 32'(bus.mem_address), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("mr_req_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("mr_done_after", 32'(bus.done), 32'd0);
    n0 = obs_rd_data.size();
    applyReadStimulus(10'h010, 0);
    checkOutput("mr_mem_kept", 32'(obs_rd_data[n0]), 32'hA0);

    // Back-to-back writes: second request presented in the done cycle
    $display("[TB] back-to-back writes");
    wbuf[0] = 8'hC0; wbuf[1] = 8'hC1;
    applyStimulus(10'h200, 1, 16'hFFFF, 0, wc);
    checkOutput("b2b_done", 32'(bus.done), 32'd1);
    checkOutput("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) wbuf[i] = lit_d[i];
    n0 = obs_wr_addr.size();
    applyStimulus(10'h300, 2, 16'hFFFF, 0, wc);
    checkOutput("b2b_no_wait", 32'(wc), 32'd0);
    checkOutput("b2b_write_count", 32'(obs_wr_addr.size() - n0), 32'd3);
    @(posedge clk); #1;
    n0 = obs_rd_data.size();
    applyReadStimulus(10'h300, 2);
    for (int i = 0; i < 3; i++) checkOutput("b2b_rd_data", 32'(obs_rd_data[n0 + i]), 32'(lit_d[i]));
    n0 = obs_rd_data.size();
    applyReadStimulus(10'h200, 1);
    checkOutput("b2b_first_kept", 32'(obs_rd_data[n0 + 1]), 32'hC1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_idle", 32'(bus.busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
